// File: rtl/switch_pkg.sv
// Shared types and constants for the packet switch datapath.
package switch_pkg;

  localparam int MAX_PKT_BYTES = 66;
  localparam int NUM_PORTS     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEND
  } state_t;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/switch_byte_fifo.sv
// Byte FIFO holding {eop, byte} entries with a registered read port.
// The read output only changes on a pop, so it doubles as the output data register.
module switch_byte_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  entry_t        i_wr_entry,
  output logic          o_wr_ready,
  input  logic          i_rd_en,
  output entry_t        o_rd_entry,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_used
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_used;
  logic [AW:0]   w_used_next;
  logic          r_wr_ready;
  entry_t        r_rd_entry;
  logic          w_wr_fire;
  logic          w_rd_fire;

  assign w_wr_fire  = i_wr_en && r_wr_ready;
  assign w_rd_fire  = i_rd_en && (r_used != '0);

  assign o_wr_ready = r_wr_ready;
  assign o_rd_entry = r_rd_entry;
  assign o_full     = (r_used == LP_FULL);
  assign o_empty    = (r_used == '0);
  assign o_used     = r_used;

  // Occupancy after this edge; also feeds the registered write-ready flag.
  always_comb begin
    w_used_next = r_used;
    case ({w_wr_fire, w_rd_fire})
      2'b10:   w_used_next = r_used + (AW+1)'(1);
      2'b01:   w_used_next = r_used - (AW+1)'(1);
      default: w_used_next = r_used;
    endcase
  end

  // Storage array write.
  // NOTE: the memory has no reset; contents are only observable after a write, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= i_wr_entry;
    end
  end

  // Pointers, occupancy, write-ready and registered read data.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_used     <= '0;
      r_wr_ready <= 1'b0;
      r_rd_entry <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_fire) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_rd_entry <= r_mem[r_rd_ptr];
      end
      r_used     <= w_used_next;
      r_wr_ready <= (w_used_next < LP_FULL);
    end
  end

endmodule

// File: rtl/switch_out_port.sv
// Egress port: buffers bytes from the switch core and hands out whole packets
// on a ready/read byte stream, tagging every byte with a constant port id.
module switch_out_port
  import switch_pkg::*;
#(
  parameter logic [7:0] PORT_ID = 8'd0,
  parameter int         DEPTH   = 256,
  parameter int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_eop,
  output logic          in_ready,
  output logic          ready,
  input  logic          read,
  output logic [7:0]    data,
  output logic [7:0]    port,
  output logic [AW:0]   pkt_count
);

  state_t      r_state;
  state_t      w_state_next;
  logic [AW:0] r_pkt_count;
  logic        w_pop;
  logic        w_wr_fire;
  logic        w_consume;
  logic        w_inc;
  logic        w_dec;
  entry_t      w_head;
  entry_t      w_wr_entry;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [AW:0] w_fifo_used;

  assign w_wr_entry = '{eop: in_eop, data: in_data};

  switch_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (in_valid),
    .i_wr_entry (w_wr_entry),
    .o_wr_ready (in_ready),
    .i_rd_en    (w_pop),
    .o_rd_entry (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_used     (w_fifo_used)
  );

  assign port      = PORT_ID;
  assign data      = w_head.data;
  assign ready     = (r_state != IDLE);
  assign pkt_count = r_pkt_count;

  assign w_wr_fire = in_valid && in_ready;
  assign w_consume = ready && read;
  assign w_inc     = w_wr_fire && in_eop;
  assign w_dec     = w_consume && w_head.eop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and FIFO pop. A packet is only armed once its eop is counted,
  // so an incomplete packet is never presented.
  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pkt_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = ARMED;
        end
      end
      ARMED, SEND: begin
        if (read) begin
          if (w_head.eop) begin
            // Another whole packet behind this one: load its first byte, stay ready.
            if (r_pkt_count > (AW+1)'(1)) begin
              w_pop        = 1'b1;
              w_state_next = ARMED;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_pop        = 1'b1;
            w_state_next = SEND;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Complete-packet counter, including the packet currently being transferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pkt_count <= r_pkt_count + (AW+1)'(1);
        2'b01:   r_pkt_count <= r_pkt_count - (AW+1)'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(w_pop && w_fifo_empty));
  a_full_blocks:  assert property (@(posedge clk) disable iff (reset) !(w_fifo_full && in_ready));
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) r_pkt_count <= w_fifo_used + (AW+1)'(1));

endmodule

// File: tb/tb_switch_out_port.sv
// Self-checking bench for switch_out_port: a queue of accepted bytes plus a
// count of accepted-minus-consumed eops predicts every delivered byte and pkt_count.
module tb_switch_out_port;
  import switch_pkg::*;

  localparam int         DEPTH   = 256;
  localparam int         AW      = 8;
  localparam logic [7:0] PORT_ID = 8'h2C;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_eop;
  logic          in_ready;
  logic          ready;
  logic          read;
  logic [7:0]    data;
  logic [7:0]    port;
  logic [AW:0]   pkt_count;

  int checks = 0;
  int errors = 0;

  entry_t      exp_q[$];
  logic [AW:0] m_pkts;

  switch_out_port #(
    .PORT_ID (PORT_ID),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .ready     (ready),
    .read      (read),
    .data      (data),
    .port      (port),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, predict what the edge does, then check afterwards.
  task automatic tick(input logic v, input logic [7:0] d, input logic e, input logic rd);
    logic wfire;
    logic cfire;
    entry_t ent;
    in_valid = v;
    in_data  = d;
    in_eop   = e;
    read     = rd;
    wfire = v && (in_ready === 1'b1);
    cfire = rd && (ready === 1'b1);
    if (cfire) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL consume: byte %h presented but nothing expected", data);
      end else if (data !== exp_q[0].data) begin
        errors++;
        $display("FAIL consume: data got %h expected %h", data, exp_q[0].data);
      end
    end
    @(posedge clk);
    #1;
    if (cfire && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      if (ent.eop) m_pkts = m_pkts - 1'b1;
    end
    if (wfire) begin
      exp_q.push_back('{eop: e, data: d});
      if (e) m_pkts = m_pkts + 1'b1;
    end
    checks++;
    if (pkt_count !== m_pkts) begin
      errors++;
      $display("FAIL pkt_count: got %0d expected %0d", pkt_count, m_pkts);
    end
    checks++;
    if (ready === 1'b1 && m_pkts == 0) begin
      errors++;
      $display("FAIL ready: got 1 expected 0 with no complete packet stored");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_eop = 1'b0; read = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_pkts = '0;
    checks++;
    if (ready !== 1'b0 || in_ready !== 1'b0 || pkt_count !== '0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ready=%b in_ready=%b pkt_count=%0d data=%h expected 0 0 0 00",
               ready, in_ready, pkt_count, data);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: in_ready=%b ready=%b expected 1 0", in_ready, ready);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && ready !== 1'b1; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready got %b expected 1 within budget", ready);
    end
  endtask

  task automatic write_pkt(input int len);
    for (int i = 0; i < len; i++) tick(1'b1, 8'($urandom), (i == len - 1), 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (port !== PORT_ID) begin
      errors++;
      $display("FAIL port: got %h expected %h", port, PORT_ID);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] bytes [4];
    bytes = '{8'h08, 8'hA1, 8'hA2, 8'h5B};
    tick(1'b0, 8'hFF, 1'b1, 1'b1);  // eop without valid must not count
    for (int i = 0; i < 4; i++) tick(1'b1, bytes[i], (i == 3), 1'b1);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: ready got %b expected 0 right after eop write", ready);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ready !== 1'b1 || data !== 8'h08) begin
      errors++;
      $display("FAIL latency: ready=%b data=%h expected 1 08", ready, data);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (data !== 8'h5B || pkt_count !== 1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL last_byte: data=%h pkt_count=%0d ready=%b expected 5b 1 1", data, pkt_count, ready);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ready !== 1'b0 || pkt_count !== 0 || data !== 8'h5B) begin
      errors++;
      $display("FAIL end_single: ready=%b pkt_count=%0d data=%h expected 0 0 5b", ready, pkt_count, data);
    end
  endtask

  task automatic test_back_to_back();
    write_pkt(3);
    write_pkt(5);
    checks++;
    if (pkt_count !== 2 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: pkt_count=%0d ready=%b expected 2 1", pkt_count, ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap: ready got %b expected 1 before byte %0d", ready, i);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      if (i == 2) begin
        checks++;
        if (pkt_count !== 1) begin
          errors++;
          $display("FAIL b2b_mid: pkt_count got %0d expected 1", pkt_count);
        end
      end
    end
    checks++;
    if (ready !== 1'b0 || pkt_count !== 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: ready=%b pkt_count=%0d left=%0d expected 0 0 0", ready, pkt_count, exp_q.size());
    end
  endtask

  task automatic test_read_pause();
    int         pat [8];
    logic [7:0] prev;
    pat = '{1, 0, 0, 1, 1, 1, 1, 1};
    write_pkt(6);
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      prev = data;
      tick(1'b0, 8'h00, 1'b0, pat[i][0]);
      if (pat[i] == 0) begin
        checks++;
        if (data !== prev || ready !== 1'b1) begin
          errors++;
          $display("FAIL pause_hold: data=%h ready=%b expected %h 1", data, ready, prev);
        end
      end
    end
    checks++;
    if (ready !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pause_end: ready=%b left=%0d expected 0 0", ready, exp_q.size());
    end
  endtask

  task automatic test_random();
    entry_t src[$];
    int     len;
    logic   v;
    logic   acc;
    for (int p = 0; p < 80; p++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) src.push_back('{eop: (i == len - 1), data: 8'($urandom)});
    end
    for (int c = 0; c < 600; c++) begin
      v   = (src.size() > 0) && ($urandom_range(0, 99) < 70);
      acc = v && (in_ready === 1'b1);
      tick(v, v ? src[0].data : 8'h00, v ? src[0].eop : 1'b0, ($urandom_range(0, 99) < 60));
      if (acc) void'(src.pop_front());
    end
    for (int c = 0; c < 1000 && (src.size() > 0 || exp_q.size() > 0 || ready === 1'b1); c++) begin
      v   = (src.size() > 0);
      acc = v && (in_ready === 1'b1);
      tick(v, v ? src[0].data : 8'h00, v ? src[0].eop : 1'b0, 1'b1);
      if (acc) void'(src.pop_front());
    end
    checks++;
    if (exp_q.size() != 0 || src.size() != 0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: left=%0d unsent=%0d ready=%b expected 0 0 0", exp_q.size(), src.size(), ready);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill: in_ready got %b expected 1 at byte %0d", in_ready, i);
      end
      tick(1'b1, 8'($urandom), 1'b0, 1'b1);
    end
    checks++;
    if (in_ready !== 1'b0 || ready !== 1'b0 || pkt_count !== 0) begin
      errors++;
      $display("FAIL full: in_ready=%b ready=%b pkt_count=%0d expected 0 0 0", in_ready, ready, pkt_count);
    end
    tick(1'b1, 8'hEE, 1'b1, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ready !== 1'b0 || pkt_count !== 0) begin
      errors++;
      $display("FAIL full_eop: ready=%b pkt_count=%0d expected 0 0", ready, pkt_count);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    write_pkt(6);
    wait_ready();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();
    write_pkt(3);
    wait_ready();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (ready !== 1'b0 || exp_q.size() != 0 || pkt_count !== 0) begin
      errors++;
      $display("FAIL post_reset_pkt: ready=%b left=%0d pkt_count=%0d expected 0 0 0", ready, exp_q.size(), pkt_count);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_eop = 1'b0; read = 1'b0;
    m_pkts = '0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_read_pause();
    test_random();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_out_port.md
Name: switch_out_port

Overview:
- Egress stage of the packet switch. Sits directly between the switch core and the per-port packet receiver.
- Buffers packet bytes coming from the core and marks where each packet ends.
- Once at least one whole packet is stored, presents it on a ready/read byte-stream interface, one byte per clock.
- Drives a constant port identifier with every byte so the consumer can tag received data.

Parameters:
- PORT_ID, 8'd0, value driven on port output.
- DEPTH, 256, byte storage entries; must be a power of 2, at least 2×66.
- AW, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  core presents a byte this cycle.
- in_data  input  8  byte from core.
- in_eop  input  1  byte is the last byte of its packet.
- in_ready  output  1  block can accept a byte this cycle.
- ready  output  1  a packet is available or is being transferred.
- read  input  1  consumer is taking bytes.
- data  output  8  current output byte.
- port  output  8  constant PORT_ID.
- pkt_count  output  AW+1  complete packets held, including one in transfer.

Behaviour:
- Reset values:
  - ready=0, data=8'h00, in_ready=0 during the reset cycle then 1.
  - pkt_count=0; pointers and byte count cleared.
  - port=PORT_ID at all times.
- Storage:
  - 9-bit entries {eop, byte}.
  - Write accepted when in_valid && in_ready.
  - in_ready = (used < DEPTH), registered from the next-state count.
- Packet count:
  - Increments on an accepted write with in_eop=1.
  - Decrements when a byte with eop=1 is consumed.
  - Simultaneous increment and decrement leave it unchanged.
- FSM states: IDLE, ARMED, SEND.
  - IDLE → ARMED when pkt_count>0 (next-cycle view). On that edge, data loads the head byte and ready=1.
  - ARMED → SEND on the first posedge with read=1. That edge consumes the head byte.
  - SEND: each posedge with read=1 && ready=1 consumes the current byte and loads the next byte onto data.
  - read=0 in SEND pauses the transfer: data and ready are held, nothing is consumed.
  - When the consumed byte has eop=1:
    - if another complete packet is stored, stay ready=1, load its first byte, go to ARMED;
    - otherwise ready=0, data holds its last value, go to IDLE.
- Latency:
  - Minimum of 2 clocks from the write of an eop byte to ready=1.
  - Steady state of 1 byte per clock while read=1.
- Boundaries:
  - Buffer full: in_ready=0; a write and a read in the same cycle free one entry next cycle.
  - Pointers wrap modulo DEPTH.
  - read=1 while ready=0 is ignored.
  - An incomplete packet is never presented, whatever its length.
  - in_eop with in_valid=0 is ignored.
- Reset mid-operation: everything is flushed on the next posedge; stored bytes are lost and ready drops.

Decomposition:
- Shared package switch_pkg:
  - typedef state_t {IDLE, ARMED, SEND};
  - typedef entry_t {logic eop; logic [7:0] data};
  - constants MAX_PKT_BYTES=66 and NUM_PORTS=4.
- One sub-module: switch_byte_fifo (DEPTH×entry_t, registered read, full/empty/used).
- The FSM and packet count live in switch_out_port.

Test Plan:
1. Reset then idle → ready=0, in_ready=1, pkt_count=0, port=PORT_ID.
2. Write a 4-byte packet 8'h08, A1, A2, 5B (eop on 5B); hold read=1 → ready rises 2 clocks after the eop write, then bytes 08, A1, A2, 5B on 4 consecutive posedges, ready=0 after 5B, pkt_count 1→0.
3. Two back-to-back packets (3 and 5 bytes), read held at 1 → 8 bytes delivered with no idle cycle and ready continuously 1; pkt_count reads 2, then 1, then 0.
4. Read toggled 1,0,0,1 mid-packet → data held stable while read=0, no byte skipped or repeated.
5. Fill with DEPTH bytes, no eop on the last → in_ready=0, ready=0; then write the eop byte in the same cycle a byte is freed… not possible, so flush with reset → in_ready=1, pkt_count=0.
6. Assert reset during SEND after 2 of 6 bytes → next posedge ready=0, pkt_count=0; a new 3-byte packet afterwards delivers correctly.
